// File: rtl/reg_xfer_pkg.sv
// Shared types for the register-to-register transfer controller.
// Optional read-back verify stage is enabled by defining XFER_VERIFY_EN.
package reg_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    SETUP  = 3'd2,
    WRITE  = 3'd3,
`ifdef XFER_VERIFY_EN
    DONE   = 3'd4,
    VERIFY = 3'd5
`else
    DONE   = 3'd4
`endif
  } state_t;

`ifdef XFER_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  // Index width for a register count; never below one bit.
  function automatic int idx_width(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/reg_xfer_ctrl_onehot_dec.sv
// Index to one-hot decoder with enable; all outputs low when en is low.
module onehot_dec
  import reg_xfer_pkg::*;
#(
  parameter  int NREG = 4,
  localparam int IW   = idx_width(NREG)
) (
  input  logic [IW-1:0]   idx,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (en && (idx == IW'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Moves one register's value to another over a shared wired-OR bus.
// Define XFER_VERIFY_EN to add a read-back VERIFY state after WRITE.
module reg_xfer_ctrl
  import reg_xfer_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int NREG = 4,
  localparam int IW   = idx_width(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [IW-1:0]   src,
  input  logic [IW-1:0]   dst,
  input  logic [N-1:0]    bus_in,
  output logic [NREG-1:0] read_en,
  output logic [NREG-1:0] write_en,
  output logic [N-1:0]    bus_out,
  output logic            busy,
  output logic            done,
  output logic            error,
  output state_t          dbg_state
);

  // Handshake: req is a level sampled only in IDLE (no ready); a caller
  // waits for busy low or the done pulse before issuing the next request.
  localparam logic [IW:0] NREG_LIM = (IW+1)'(NREG);

  state_t        r_state;
  logic [IW-1:0] r_src;
  logic [IW-1:0] r_dst;
  logic [N-1:0]  r_data;
  logic          r_rd_go;
  logic          r_rd_dst;
  logic          r_wr_go;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic          w_bad_idx;
  logic [IW-1:0] w_rd_idx;

  assign w_bad_idx = ({1'b0, src} >= NREG_LIM) || ({1'b0, dst} >= NREG_LIM);
  assign w_rd_idx  = r_rd_dst ? r_dst : r_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_data   <= '0;
      r_rd_go  <= 1'b0;
      r_rd_dst <= 1'b0;
      r_wr_go  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            if (w_bad_idx) begin
              r_error <= 1'b1;
            end else begin
              r_src    <= src;
              r_dst    <= dst;
              r_rd_go  <= 1'b1;
              r_rd_dst <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= READ;
            end
          end
        end
        READ: begin
          r_data  <= bus_in;
          r_rd_go <= 1'b0;
          r_state <= SETUP;
        end
        SETUP: begin
          r_wr_go <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
          r_wr_go <= 1'b0;
`ifdef XFER_VERIFY_EN
          r_rd_go  <= 1'b1;
          r_rd_dst <= 1'b1;
          r_state  <= VERIFY;
`else
          r_done   <= 1'b1;
          r_state  <= DONE;
`endif
        end
`ifdef XFER_VERIFY_EN
        VERIFY: begin
          r_rd_go  <= 1'b0;
          r_rd_dst <= 1'b0;
          r_done   <= 1'b1;
          r_error  <= VERIFY_EN && (bus_in != r_data);
          r_state  <= DONE;
        end
`endif
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_rd_go  <= 1'b0;
          r_rd_dst <= 1'b0;
          r_wr_go  <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  // Strobes are registered enables through a decoder, so reset kills them at once.
  onehot_dec #(.NREG(NREG)) u_rd_dec (
    .idx    (w_rd_idx),
    .en     (r_rd_go),
    .onehot (read_en)
  );

  onehot_dec #(.NREG(NREG)) u_wr_dec (
    .idx    (r_dst),
    .en     (r_wr_go),
    .onehot (write_en)
  );

  assign bus_out   = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl with a behavioural register bank (reg1 has bit 0 stuck low).
// Expectations follow the XFER_VERIFY_EN build setting.
module tb_reg_xfer_ctrl;
  import reg_xfer_pkg::*;

`ifdef XFER_VERIFY_EN
  localparam bit VFY      = 1'b1;
  localparam int LAT_DONE = 5;
`else
  localparam bit VFY      = 1'b0;
  localparam int LAT_DONE = 4;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance, NREG=4
  logic       req = 1'b0;
  logic [1:0] src = '0;
  logic [1:0] dst = '0;
  logic [7:0] bus_in;
  logic [3:0] read_en, write_en;
  logic [7:0] bus_out;
  logic       busy, done, error;
  state_t     dbg_state;
  logic [7:0] regs [4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
  logic [7:0] stuck[4] = '{8'h00, 8'h01, 8'h00, 8'h00};

  reg_xfer_ctrl #(.N(8), .NREG(4)) dut (
    .clk(clk), .reset(reset), .req(req), .src(src), .dst(dst),
    .bus_in(bus_in), .read_en(read_en), .write_en(write_en), .bus_out(bus_out),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  always_comb begin
    bus_in = '0;
    for (int i = 0; i < 4; i++) if (read_en[i]) bus_in = bus_in | regs[i];
  end
  always @(posedge clk)
    for (int i = 0; i < 4; i++) if (write_en[i]) regs[i] <= bus_out & ~stuck[i];

  // second instance, NREG=3
  logic       req3 = 1'b0;
  logic [1:0] src3 = '0;
  logic [1:0] dst3 = '0;
  logic [7:0] bus_in3;
  logic [2:0] read_en3, write_en3;
  logic [7:0] bus_out3;
  logic       busy3, done3, error3;
  state_t     dbg_state3;
  logic [7:0] regs3[3] = '{8'h11, 8'h22, 8'h33};

  reg_xfer_ctrl #(.N(8), .NREG(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .src(src3), .dst(dst3),
    .bus_in(bus_in3), .read_en(read_en3), .write_en(write_en3), .bus_out(bus_out3),
    .busy(busy3), .done(done3), .error(error3), .dbg_state(dbg_state3)
  );

  always_comb begin
    bus_in3 = '0;
    for (int i = 0; i < 3; i++) if (read_en3[i]) bus_in3 = bus_in3 | regs3[i];
  end
  always @(posedge clk)
    for (int i = 0; i < 3; i++) if (write_en3[i]) regs3[i] <= bus_out3;

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] shadow[4];
  int n_vec = 0;
  int n_err = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // strobe legality on every cycle
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      chk("rw_overlap", 32'((read_en != 0) && (write_en != 0)), 0);
      chk("rd_onehot0", 32'($onehot0(read_en)), 1);
      chk("wr_onehot0", 32'($onehot0(write_en)), 1);
      chk("rw3_zero",   32'({read_en3 != 0, write_en3 != 0} & {2{busy3 == 1'b0}}), 0);
    end
  end

  // One full transfer; req is driven in the current cycle and sampled at the next edge.
  task automatic do_xfer(input int s, input int d, input logic [7:0] exp_d,
                         input logic [7:0] exp_reg, input bit intrude, input bit exp_mis);
    logic [3:0] e_rd, e_wr;
    req = 1'b1; src = 2'(s); dst = 2'(d);
    exp_q.push_back(exp_d);
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= LAT_DONE + 1; c++) begin
      e_rd = '0;
      e_wr = '0;
      if (c == 1) e_rd = 4'b0001 << s;
      if (VFY && c == 4) e_rd = 4'b0001 << d;
      if (c == 3) e_wr = 4'b0001 << d;
      chk("read_en",  32'(read_en),  32'(e_rd));
      chk("write_en", 32'(write_en), 32'(e_wr));
      chk("busy",  32'(busy),  32'(c <= LAT_DONE));
      chk("done",  32'(done),  32'(c == LAT_DONE));
      chk("error", 32'(error), 32'((c == LAT_DONE) && VFY && exp_mis));
      if (c == 2) chk("bus_setup", 32'(bus_out), 32'(exp_d));
      if (c == 3) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $error("FAIL sb_empty observed=write expected=queued_data");
        end else begin
          chk("bus_write", 32'(bus_out), 32'(exp_q.pop_front()));
        end
      end
      if (intrude && c == 2) begin req = 1'b1; src = 2'd0; dst = 2'd3; end
      if (intrude && c == 3) req = 1'b0;
      if (c <= LAT_DONE) begin @(posedge clk); #1; end
    end
    chk("reg_after", 32'(regs[d]), 32'(exp_reg));
  endtask

  initial begin
    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_read_en",  32'(read_en), 0);
    chk("rst_write_en", 32'(write_en), 0);
    chk("rst_bus_out",  32'(bus_out), 0);
    chk("rst_busy",     32'({busy, done, error}), 0);
    chk("rst_state",    32'(dbg_state), 32'(IDLE));
    chk("rst3_flags",   32'({busy3, done3, error3, read_en3, write_en3}), 0);
    reset  = 1'b0;
    mon_on = 1'b1;

    // basic transfer with a second request landing while busy
    do_xfer(1, 2, 8'hA5, 8'hA5, 1'b1, 1'b0);
    chk("guard_reg3", 32'(regs[3]), 32'h0000_00FF);
    // back-to-back self transfer
    do_xfer(0, 0, 8'h3C, 8'h3C, 1'b0, 1'b0);

    // reset during SETUP
    req = 1'b1; src = 2'd0; dst = 2'd2;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_state", 32'(dbg_state), 32'(SETUP));
    reset = 1'b1; #1;
    chk("midrst_strobes", 32'({read_en, write_en}), 0);
    chk("midrst_flags",   32'({busy, done, error}), 0);
    chk("midrst_bus_out", 32'(bus_out), 0);
    @(posedge clk); #1;
    chk("midrst_no_wr", 32'(write_en), 0);
    chk("midrst_reg2",  32'(regs[2]), 32'h0000_00A5);
    reset = 1'b0;
    do_xfer(0, 2, 8'h3C, 8'h3C, 1'b0, 1'b0);

    // stuck destination, then healthy destination
    do_xfer(3, 1, 8'hFF, 8'hFE, 1'b0, 1'b1);
    do_xfer(3, 2, 8'hFF, 8'hFF, 1'b0, 1'b0);

    // random transfers, avoiding the stuck register as destination
    shadow = '{8'h3C, 8'hFE, 8'hFF, 8'hFF};
    for (int k = 0; k < 4; k++) begin
      int s, r, d;
      s = $urandom_range(0, 3);
      r = $urandom_range(0, 2);
      d = (r == 0) ? 0 : r + 1;
      do_xfer(s, d, shadow[s], shadow[s], 1'b0, 1'b0);
      shadow[d] = shadow[s];
    end

    // out-of-range requests on the NREG=3 instance
    for (int k = 0; k < 2; k++) begin
      req3 = 1'b1; src3 = (k == 0) ? 2'd3 : 2'd0; dst3 = (k == 0) ? 2'd0 : 2'd3;
      @(posedge clk); #1; req3 = 1'b0;
      chk("oor_error", 32'(error3), 1);
      chk("oor_busy",  32'(busy3), 0);
      chk("oor_strobe", 32'({read_en3, write_en3}), 0);
      @(posedge clk); #1;
      chk("oor_error_end", 32'(error3), 0);
      chk("oor_busy_end",  32'(busy3), 0);
    end
    // legal transfer on the NREG=3 instance
    req3 = 1'b1; src3 = 2'd2; dst3 = 2'd0;
    @(posedge clk); #1; req3 = 1'b0;
    for (int c = 1; c <= LAT_DONE; c++) begin
      chk("n3_done", 32'(done3), 32'(c == LAT_DONE));
      if (c < LAT_DONE) begin @(posedge clk); #1; end
    end
    chk("n3_reg0", 32'(regs3[0]), 32'h0000_0033);
    chk("n3_error", 32'(error3), 0);

    @(posedge clk); #1;
    mon_on = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
